// File: rtl/lock_key_loader.sv
// lock_key_loader: serial key intake with even-parity check for locked c432.
// Drives a decoy key until a parity-verified key has been committed.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   start           single-cycle load request
//   bit_valid       key-store bit valid
//   bit_data        key-store bit value (LSB first, then one parity bit)
//   bit_ready       loader accepts a bit this cycle (LOAD/PARITY)
//   key_q           key bus: [3:0] -> p1..p4, [13:4] -> X_1..X_10
//   key_valid       key_q holds a parity-verified key
//   busy            load in progress (LOAD or PARITY)
//   err             retry limit reached, sticky until reset
//   retry_cnt       parity failures in the current load session
module lock_key_loader #(
    parameter int               KEY_W       = 14,
    parameter logic [KEY_W-1:0] DEFAULT_KEY = '0,
    parameter int               MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic             bit_ready,
    output logic [KEY_W-1:0] key_q,
    output logic             key_valid,
    output logic             busy,
    output logic             err,
    output logic [1:0]       retry_cnt
);

    localparam int CW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(KEY_W - 1);
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PARITY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [KEY_W-1:0] shadow;
    logic             xfer;
    logic             parity_ok;
    logic [2:0]       retry_inc;

    assign bit_ready = (state == S_LOAD) || (state == S_PARITY);
    assign busy      = bit_ready;
    assign xfer      = bit_valid && bit_ready;
    // Even parity over the key plus the parity bit itself.
    assign parity_ok = ~(^shadow ^ bit_data);
    assign retry_inc = {1'b0, retry_cnt} + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shadow    <= '0;
            key_q     <= DEFAULT_KEY;
            key_valid <= 1'b0;
            err       <= 1'b0;
            retry_cnt <= 2'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        cnt       <= '0;
                        shadow    <= '0;
                        retry_cnt <= 2'd0;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        shadow[cnt] <= bit_data;
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= S_PARITY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (xfer) begin
                        if (parity_ok) begin
                            key_q     <= shadow;
                            key_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (retry_inc < MAX_R) begin
                            // Retry: go straight back to LOAD, no ready gap.
                            retry_cnt <= retry_inc[1:0];
                            shadow    <= '0;
                            state     <= S_LOAD;
                        end else begin
                            retry_cnt <= retry_inc[1:0];
                            err       <= 1'b1;
                            state     <= S_ERROR;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        // Old key is dropped at once on a reload.
                        key_valid <= 1'b0;
                        key_q     <= DEFAULT_KEY;
                        retry_cnt <= 2'd0;
                        cnt       <= '0;
                        shadow    <= '0;
                        state     <= S_LOAD;
                    end
                end
                S_ERROR: begin
                    key_q     <= DEFAULT_KEY;
                    key_valid <= 1'b0;
                    err       <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_key_loader.sv
// tb_lock_key_loader: directed scoreboard bench for lock_key_loader.
// Expected commits are queued by stimulus and checked by a monitor.
module tb_lock_key_loader;

    localparam int KEY_W = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_data = 1'b0;
    logic             bit_ready;
    logic [KEY_W-1:0] key_q;
    logic             key_valid;
    logic             busy;
    logic             err;
    logic [1:0]       retry_cnt;

    int               total = 0;
    int               bad = 0;
    int               cycles = 0;
    int               c0;
    logic             gaps = 1'b0;
    logic             prev_kv = 1'b0;
    logic [KEY_W-1:0] exp_q[$];

    lock_key_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_ready (bit_ready),
        .key_q     (key_q),
        .key_valid (key_valid),
        .busy      (busy),
        .err       (err),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycles <= cycles + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising key_valid must match the next queued key,
    // and key_q must carry the decoy whenever key_valid is low.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid && !prev_kv) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got %0h want none",
                             key_q);
                end else begin
                    check("commit_key", int'(key_q),
                          int'(exp_q.pop_front()));
                end
            end
            if (!key_valid) check("decoy_key", int'(key_q), 0);
        end
        prev_kv = key_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int   n;
        logic r;
        n = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bit_valid = 1'b0;
                bit_data  = 1'($urandom_range(0, 1));
                tick();
            end
        end
        bit_valid = 1'b1;
        bit_data  = b;
        do begin
            r = bit_ready;
            tick();
            n++;
        end while (!r && n < 64);
        if (!r) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: got ready 0 want 1");
        end
    endtask

    // Sends key LSB first then parity; optionally pulses start
    // (with bit_valid low) just before bit index start_at.
    task automatic send_frame(input logic [KEY_W-1:0] k, input logic p,
                              input int start_at);
        for (int i = 0; i <= KEY_W; i++) begin
            if (i == start_at) begin
                bit_valid = 1'b0;
                start     = 1'b1;
                tick();
                start     = 1'b0;
            end
            send_bit((i < KEY_W) ? k[i] : p);
        end
        bit_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_key_q", int'(key_q), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_bit_ready", int'(bit_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_retry", int'(retry_cnt), 0);
        rst_n = 1'b1;
        tick();

        // bit_valid in IDLE is ignored
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        repeat (3) tick();
        check("idle_ready", int'(bit_ready), 0);
        check("idle_busy", int'(busy), 0);
        bit_valid = 1'b0;

        // Nominal load, latency start cycle -> key_valid = 17
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cycles;
        check("load_busy", int'(busy), 1);
        check("load_ready", int'(bit_ready), 1);
        exp_q.push_back(14'h2A5B);
        send_frame(14'h2A5B, 1'b0, -1);
        check("latency", cycles - c0 + 2, 17);
        check("nom_valid", int'(key_valid), 1);
        check("nom_key", int'(key_q), 'h2A5B);
        check("nom_p4_p1", int'(key_q[3:0]), 'b1011);
        check("nom_x1", int'(key_q[4]), 1);
        check("nom_busy", int'(busy), 0);

        // Reload from DONE
        pulse_start();
        check("reload_valid", int'(key_valid), 0);
        check("reload_key", int'(key_q), 0);
        check("reload_busy", int'(busy), 1);
        exp_q.push_back(14'h0F0F);
        send_frame(14'h0F0F, 1'b0, -1);
        check("reload2_valid", int'(key_valid), 1);
        check("reload2_key", int'(key_q), 'h0F0F);

        // Parity retry
        pulse_start();
        send_frame(14'h2A5B, 1'b1, -1);
        check("retry_cnt1", int'(retry_cnt), 1);
        check("retry_key", int'(key_q), 0);
        check("retry_busy", int'(busy), 1);
        check("retry_ready", int'(bit_ready), 1);
        exp_q.push_back(14'h2A5B);
        send_frame(14'h2A5B, 1'b0, -1);
        check("retry_ok_valid", int'(key_valid), 1);
        check("retry_ok_key", int'(key_q), 'h2A5B);
        check("retry_ok_cnt", int'(retry_cnt), 1);

        // Back-pressure gaps plus a start mid-load that must be ignored
        pulse_start();
        gaps = 1'b1;
        exp_q.push_back(14'h2A5B);
        send_frame(14'h2A5B, 1'b0, 5);
        gaps = 1'b0;
        check("gap_valid", int'(key_valid), 1);
        check("gap_key", int'(key_q), 'h2A5B);

        // Lockout after three bad frames
        pulse_start();
        send_frame(14'h2A5B, 1'b1, -1);
        check("lock_retry1", int'(retry_cnt), 1);
        send_frame(14'h2A5B, 1'b1, -1);
        check("lock_retry2", int'(retry_cnt), 2);
        send_frame(14'h2A5B, 1'b1, -1);
        check("lock_err", int'(err), 1);
        check("lock_retry3", int'(retry_cnt), 3);
        check("lock_ready", int'(bit_ready), 0);
        check("lock_key", int'(key_q), 0);
        check("lock_valid", int'(key_valid), 0);
        pulse_start();
        tick();
        check("lock_start_busy", int'(busy), 0);
        check("lock_start_err", int'(err), 1);
        check("lock_start_ready", int'(bit_ready), 0);

        // Reset mid-load
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("unlock_err", int'(err), 0);
        pulse_start();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_key", int'(key_q), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(bit_ready), 0);
        check("mid_rst_valid", int'(key_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(14'h1234);
        pulse_start();
        send_frame(14'h1234, 1'b1, -1);
        check("fresh_valid", int'(key_valid), 1);
        check("fresh_key", int'(key_q), 'h1234);

        repeat (2) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
